vga_sync_output: RTL
====================

// Module: vga_sync_output
// PURPOSE
//  Downstream VGA output stage for the screen drawer. Owns the master 800x525 raster timing for
//  640x480@60 and samples the drawer's 24-bit pixel colour. Emits aligned hsync/vsync/blank_n/sync_n
//  plus blanked RGB to the video DAC. Exports the raw raster position and a per-frame tick for game logic.
// PARAMETERS
//  H_SYNC         96   hsync pulse width, pixels
//  H_BP           48   horizontal back porch, pixels
//  H_ACTIVE       640  visible pixels per line
//  H_FP           16   horizontal front porch, pixels
//  V_SYNC         2    vsync pulse width, lines
//  V_BP           33   vertical back porch, lines
//  V_ACTIVE       480  visible lines per frame
//  V_FP           10   vertical front porch, lines
//  PIXEL_LATENCY  1    cycles from raster position to matching rgb_color at rgb_in (0..4)
// PORTS
//  clk          in   1   pixel clock (25 MHz); sole clock
//  reset        in   1   synchronous, active-high reset
//  rgb_in       in   24  pixel colour from screen_drawer, {R[7:0],G[7:0],B[7:0]}
//  pattern_en   in   1   1 = replace rgb_in with internal colour-bar test pattern
//  x_pos        out  10  raw horizontal counter, 0..H_TOTAL-1 (undelayed)
//  y_pos        out  10  raw vertical counter, 0..V_TOTAL-1 (undelayed)
//  frame_tick   out  1   one-cycle pulse on the last pixel of each frame (undelayed)
//  hsync        out  1   horizontal sync, active low
//  vsync        out  1   vertical sync, active low
//  blank_n      out  1   1 = visible region
//  sync_n       out  1   composite sync to DAC, tied 0
//  vga_r        out  8   red to DAC, 0 when blanked
//  vga_g        out  8   green to DAC, 0 when blanked
//  vga_b        out  8   blue to DAC, 0 when blanked
// BEHAVIOUR
//  - H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (800); V_TOTAL likewise (525). Line order: sync, BP, active, FP.
//  - x_pos increments every clk and wraps H_TOTAL-1 -> 0.
//  - y_pos increments only on the x wrap and wraps V_TOTAL-1 -> 0 on the same edge.
//  - Raw timing, computed from counters:
//    - hs_raw = (x_pos < H_SYNC)
//    - vs_raw = (y_pos < V_SYNC)
//    - act_raw = x_pos in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) AND y_pos in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE)
//    - With defaults: active x 144..783, active y 35..514.
//  - {hs,vs,act} pass through a PIXEL_LATENCY-deep shift register, then one output register.
//    - hsync = ~hs_d and vsync = ~vs_d, registered.
//    - blank_n = act_d, registered.
//    - RGB registered: act_d ? src : 24'h0.
//    - src = pattern_en ? bar colour : rgb_in.
//    - Net result: all DAC outputs at cycle t+1 describe raster position (x,y) held at cycle t-PIXEL_LATENCY.
//  - Test pattern: col = x_d - (H_SYNC+H_BP), where x_d is the delayed x.
//    - Bar index = col/80 (0..7).
//    - Colours: white, yellow, cyan, green, magenta, red, blue, black (components FF/00).
//    - pattern_en is sampled with rgb_in; toggling takes effect on the next registered pixel, no glitch on syncs.
//  - frame_tick = 1 exactly when x_pos==H_TOTAL-1 and y_pos==V_TOTAL-1; combinational from counters.
//  - Reset:
//    - x_pos = y_pos = 0; delay line cleared to inactive (hs=vs=act=0).
//    - hsync = vsync = 1, blank_n = 0, RGB = 0, frame_tick = 0.
//    - Reset mid-frame restarts the raster at (0,0) on the next cycle.
//    - First hsync low appears PIXEL_LATENCY+1 cycles after reset release.
//  - PIXEL_LATENCY=0: no shift stages; output register only.
//  - Out-of-range parameters are a synthesis error via generate-time check.
// TESTING
//  - Reset, then release; run 800*525 cycles -> frame_tick pulses once at cycle 419999.
//    - x_pos wraps 799->0 every 800 cycles; y_pos wraps 524->0.
//  - PIXEL_LATENCY=1, count cycles -> hsync low 96 cycles per line, starting 2 cycles after x_pos=0.
//    - vsync low for 1600 cycles per frame.
//  - rgb_in = 24'hA5C3F0 constant -> RGB = A5/C3/F0 only while blank_n=1 (640x480 pixels/frame), else 0.
//  - rgb_in = {14'b0,x_pos} (one-cycle registered) -> first visible pixel after each hsync = 144 (vga_b=0x90).
//  - pattern_en=1 -> pixel cols 0..79 = FFFFFF, 80..159 = FFFF00, 560..639 = 000000 on every active line.
//  - Assert reset at x=300,y=200 for 1 cycle -> next cycle x_pos=0,y_pos=0, hsync=1, blank_n=0, RGB=0.

Source files
------------

// File: rtl/vga_sync_if.sv
// Signal bundle of the VGA output stage: drawer colour in, raster position and DAC drive out.
// The output stage takes the master side; the drawer/DAC/game-logic side takes the slave side.
interface vga_sync_if;
    logic [23:0] rgb_in;
    logic        pattern_en;
    logic [9:0]  x_pos;
    logic [9:0]  y_pos;
    logic        frame_tick;
    logic        hsync;
    logic        vsync;
    logic        blank_n;
    logic        sync_n;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;

    modport master (
        input  rgb_in, pattern_en,
        output x_pos, y_pos, frame_tick, hsync, vsync, blank_n, sync_n, vga_r, vga_g, vga_b
    );

    modport slave (
        output rgb_in, pattern_en,
        input  x_pos, y_pos, frame_tick, hsync, vsync, blank_n, sync_n, vga_r, vga_g, vga_b
    );
endinterface

// File: rtl/vga_sync_output.sv
// VGA output stage: master raster counters, sync/blank generation delayed to line up with the
// drawer's pixel colour, optional colour-bar test pattern, and registered DAC outputs.
module vga_sync_output #(
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int H_ACTIVE      = 640,
    parameter int H_FP          = 16,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33,
    parameter int V_ACTIVE      = 480,
    parameter int V_FP          = 10,
    parameter int PIXEL_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    vga_sync_if.master vga
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [9:0] HS_END = 10'(H_SYNC);
    localparam logic [9:0] HA_BEG = 10'(H_SYNC + H_BP);
    localparam logic [9:0] HA_END = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] VS_END = 10'(V_SYNC);
    localparam logic [9:0] VA_BEG = 10'(V_SYNC + V_BP);
    localparam logic [9:0] VA_END = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] BAR_W  = 10'(H_ACTIVE / 8);

    if (PIXEL_LATENCY < 0 || PIXEL_LATENCY > 4) begin : g_bad_latency
        $error("vga_sync_output: PIXEL_LATENCY must be in 0..4");
    end
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_ACTIVE < 8) begin : g_bad_geometry
        $error("vga_sync_output: raster must fit 10-bit counters and hold eight bars");
    end

    // One pipeline tap: the raw timing flags plus the x needed to place the colour bars.
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic [9:0] x;
    } tap_t;

    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic        w_x_last;
    logic        w_y_last;
    tap_t        w_tap_raw;
    tap_t        w_tap_d;
    logic [9:0]  w_col;
    logic [2:0]  w_bar;
    logic [23:0] w_bar_rgb;
    logic [23:0] w_src;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_blank_n;
    logic [23:0] r_rgb;

    assign w_x_last = (r_x == H_LAST);
    assign w_y_last = (r_y == V_LAST);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_x_last) begin
            r_x <= '0;
            r_y <= w_y_last ? '0 : r_y + 10'd1;
        end else begin
            r_x <= r_x + 10'd1;
        end
    end

    always_comb begin
        w_tap_raw     = '0;
        w_tap_raw.hs  = (r_x < HS_END);
        w_tap_raw.vs  = (r_y < VS_END);
        w_tap_raw.act = (r_x >= HA_BEG) && (r_x < HA_END) && (r_y >= VA_BEG) && (r_y < VA_END);
        w_tap_raw.x   = r_x;
    end

    if (PIXEL_LATENCY == 0) begin : g_no_delay
        assign w_tap_d = w_tap_raw;
    end else begin : g_delay
        tap_t r_dly [PIXEL_LATENCY];

        always_ff @(posedge clk) begin
            // NOTE: the delay line is reset on purpose; its contents decide the sync levels right after reset.
            if (reset) begin
                for (int i = 0; i < PIXEL_LATENCY; i++) r_dly[i] <= '0;
            end else begin
                r_dly[0] <= w_tap_raw;
                for (int i = 1; i < PIXEL_LATENCY; i++) r_dly[i] <= r_dly[i-1];
            end
        end

        assign w_tap_d = r_dly[PIXEL_LATENCY-1];
    end

    assign w_col = w_tap_d.x - HA_BEG;
    assign w_bar = 3'(w_col / BAR_W);

    always_comb begin
        w_bar_rgb = 24'h000000;
        case (w_bar)
            3'd0: w_bar_rgb = 24'hFFFFFF;
            3'd1: w_bar_rgb = 24'hFFFF00;
            3'd2: w_bar_rgb = 24'h00FFFF;
            3'd3: w_bar_rgb = 24'h00FF00;
            3'd4: w_bar_rgb = 24'hFF00FF;
            3'd5: w_bar_rgb = 24'hFF0000;
            3'd6: w_bar_rgb = 24'h0000FF;
            default: w_bar_rgb = 24'h000000;
        endcase
    end

    assign w_src = vga.pattern_en ? w_bar_rgb : vga.rgb_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
            r_blank_n <= 1'b0;
            r_rgb     <= '0;
        end else begin
            r_hsync   <= ~w_tap_d.hs;
            r_vsync   <= ~w_tap_d.vs;
            r_blank_n <= w_tap_d.act;
            r_rgb     <= w_tap_d.act ? w_src : 24'h000000;
        end
    end

    assign vga.x_pos      = r_x;
    assign vga.y_pos      = r_y;
    assign vga.frame_tick = w_x_last & w_y_last;
    assign vga.hsync      = r_hsync;
    assign vga.vsync      = r_vsync;
    assign vga.blank_n    = r_blank_n;
    assign vga.sync_n     = 1'b0;
    assign vga.vga_r      = r_rgb[23:16];
    assign vga.vga_g      = r_rgb[15:8];
    assign vga.vga_b      = r_rgb[7:0];
endmodule
